// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS core types and constants
`timescale 1ns/1ps
package mips_pkg;

  localparam int DEF_INSTR_W = 32;
  localparam int DEF_ADDR_W  = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    IFID_EMPTY = 2'd0,
    IFID_BUSY  = 2'd1,
    IFID_FULL  = 2'd2
  } ifid_state_e;

endpackage

// File: rtl/ifid_entry_reg.sv
// rtl/ifid_entry_reg.sv - one instr + pc_plus1 storage slot with load enable
`timescale 1ns/1ps
module ifid_entry_reg
  import mips_pkg::*;
#(
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [INSTR_W-1:0] d_instr,
  input  logic [ADDR_W-1:0]  d_pc_plus1,
  output logic [INSTR_W-1:0] q_instr,
  output logic [ADDR_W-1:0]  q_pc_plus1
);

  // Capture the slot contents on load; reset clears to a NOP at address 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_instr    <= INSTR_W'(NOP_INSTR);
      q_pc_plus1 <= '0;
    end else if (load) begin
      q_instr    <= d_instr;
      q_pc_plus1 <= d_pc_plus1;
    end
  end

endmodule

// File: rtl/if_id_skid_register.sv
// rtl/if_id_skid_register.sv - IF/ID boundary with 2-entry skid buffer; IFID_PERF_CNT_EN adds perf counters
`timescale 1ns/1ps
module if_id_skid_register
  import mips_pkg::*;
#(
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [ADDR_W-1:0]  in_pc_plus1,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc_plus1
`ifdef IFID_PERF_CNT_EN
  ,
  output logic [31:0]        perf_accepted,
  output logic [31:0]        perf_flushed
`endif
);

  ifid_state_e state_q;
  ifid_state_e state_d;

  logic in_fire;
  logic out_fire;
  logic main_load;
  logic skid_load;
  logic main_from_skid;

  logic [INSTR_W-1:0] skid_instr;
  logic [ADDR_W-1:0]  skid_pc_plus1;
  logic [INSTR_W-1:0] main_d_instr;
  logic [ADDR_W-1:0]  main_d_pc_plus1;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  assign main_d_instr    = main_from_skid ? skid_instr    : in_instr;
  assign main_d_pc_plus1 = main_from_skid ? skid_pc_plus1 : in_pc_plus1;

  // Next-state and slot-load decode; flush overrides everything and blocks loads.
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d = IFID_EMPTY;
    end else begin
      case (state_q)
        IFID_EMPTY: begin
          if (in_fire) begin
            main_load = 1'b1;
            state_d   = IFID_BUSY;
          end
        end
        IFID_BUSY: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            skid_load = 1'b1;
            state_d   = IFID_FULL;
          end else if (out_fire) begin
            state_d = IFID_EMPTY;
          end
        end
        IFID_FULL: begin
          if (out_fire) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            state_d        = IFID_BUSY;
          end
        end
        default: state_d = IFID_EMPTY;
      endcase
    end
  end

  // State plus registered handshake outputs, all derived from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IFID_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d != IFID_FULL);
      out_valid <= (state_d != IFID_EMPTY);
    end
  end

  ifid_entry_reg #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W)) u_main (
    .clk        (clk),
    .reset      (reset),
    .load       (main_load),
    .d_instr    (main_d_instr),
    .d_pc_plus1 (main_d_pc_plus1),
    .q_instr    (out_instr),
    .q_pc_plus1 (out_pc_plus1)
  );

  ifid_entry_reg #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W)) u_skid (
    .clk        (clk),
    .reset      (reset),
    .load       (skid_load),
    .d_instr    (in_instr),
    .d_pc_plus1 (in_pc_plus1),
    .q_instr    (skid_instr),
    .q_pc_plus1 (skid_pc_plus1)
  );

`ifdef IFID_PERF_CNT_EN
  logic [1:0] drop_cnt;

  // Entries lost to a flush: main unless decode takes it this cycle, plus skid when full.
  assign drop_cnt = 2'(out_valid & ~out_ready) + 2'(state_q == IFID_FULL);

  // Accepted/flushed counters; both wrap naturally at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_accepted <= '0;
      perf_flushed  <= '0;
    end else begin
      if (in_fire && !flush) perf_accepted <= perf_accepted + 32'd1;
      if (flush)             perf_flushed  <= perf_flushed + 32'(drop_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_if_id_skid_register.sv
// tb/tb_if_id_skid_register.sv - self-checking bench for if_id_skid_register
`timescale 1ns/1ps
module tb_if_id_skid_register;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc_plus1;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc_plus1;
`ifdef IFID_PERF_CNT_EN
  logic [31:0] perf_accepted;
  logic [31:0] perf_flushed;
`endif

  int n_cmp;
  int n_err;

  if_id_skid_register dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_pc_plus1  (in_pc_plus1),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_pc_plus1 (out_pc_plus1)
`ifdef IFID_PERF_CNT_EN
    ,
    .perf_accepted(perf_accepted),
    .perf_flushed (perf_flushed)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a 2-deep FIFO; ready means "fewer than two held".
  logic [63:0] mq[$];
  int unsigned m_acc;
  int unsigned m_flu;
  bit          m_ifire;
  bit          m_ofire;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_acc = 0;
      m_flu = 0;
    end else begin
      m_ifire = in_valid && (mq.size() < 2);
      m_ofire = out_ready && (mq.size() > 0);
      if (flush) begin
        m_flu = m_flu + mq.size() - (m_ofire ? 1 : 0);
        mq.delete();
      end else begin
        if (m_ofire) void'(mq.pop_front());
        if (m_ifire) begin
          mq.push_back({in_instr, in_pc_plus1});
          m_acc++;
        end
      end
    end
  end

  // Per-cycle compare against the model, plus the hold-while-stalled rule.
  logic        p_hold;
  logic [31:0] p_instr;
  logic [31:0] p_pc;

  always @(negedge clk) begin
    if (reset) begin
      p_hold = 1'b0;
    end else begin
      chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
      chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
      if (mq.size() > 0) begin
        chk("out_instr", 64'(out_instr), 64'(mq[0][63:32]));
        chk("out_pc_plus1", 64'(out_pc_plus1), 64'(mq[0][31:0]));
      end
      if (p_hold && out_valid) begin
        chk("stable_instr", 64'(out_instr), 64'(p_instr));
        chk("stable_pc", 64'(out_pc_plus1), 64'(p_pc));
      end
`ifdef IFID_PERF_CNT_EN
      chk("perf_accepted", 64'(perf_accepted), 64'(m_acc));
      chk("perf_flushed", 64'(perf_flushed), 64'(m_flu));
`endif
      p_hold  = out_valid && !out_ready && !flush;
      p_instr = out_instr;
      p_pc    = out_pc_plus1;
    end
  end

  // Apply one cycle of inputs, then step to just after the next rising edge.
  task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                     input logic ordy, input logic fl);
    in_valid    = v;
    in_instr    = ins;
    in_pc_plus1 = pc;
    out_ready   = ordy;
    flush       = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_chk(input string nm);
    chk({nm, "_valid"}, 64'(out_valid), 64'd0);
    chk({nm, "_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    p_hold = 1'b0;
    reset = 1'b1;
    in_valid = 0; in_instr = 0; in_pc_plus1 = 0; flush = 0; out_ready = 0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // Reset state
    cyc(0, 32'h0, 32'h0, 0, 0);
    idle_chk("rst");
    chk("rst_instr", 64'(out_instr), 64'h0);
    chk("rst_pc", 64'(out_pc_plus1), 64'h0);

    // Streaming at full rate
    cyc(1, 32'h20080005, 32'd1, 1, 0);
    chk("s1_valid", 64'(out_valid), 64'd1);
    chk("s1_instr", 64'(out_instr), 64'h20080005);
    chk("s1_ready", 64'(in_ready), 64'd1);
    cyc(1, 32'h20090003, 32'd2, 1, 0);
    chk("s2_instr", 64'(out_instr), 64'h20090003);
    chk("s2_pc", 64'(out_pc_plus1), 64'd2);
    cyc(1, 32'h01095020, 32'd3, 1, 0);
    chk("s3_instr", 64'(out_instr), 64'h01095020);
    chk("s3_ready", 64'(in_ready), 64'd1);
    cyc(0, 32'h0, 32'h0, 1, 0);
    idle_chk("s_end");

    // Fill to FULL with decode stalled, then drain in order
    cyc(1, 32'h11111111, 32'd10, 0, 0);
    chk("f1_instr", 64'(out_instr), 64'h11111111);
    chk("f1_ready", 64'(in_ready), 64'd1);
    cyc(1, 32'h22222222, 32'd11, 0, 0);
    chk("f2_ready", 64'(in_ready), 64'd0);
    chk("f2_instr", 64'(out_instr), 64'h11111111);
    cyc(1, 32'h33333333, 32'd12, 0, 0);
    chk("f3_instr", 64'(out_instr), 64'h11111111);
    cyc(0, 32'h0, 32'h0, 1, 0);
    chk("d1_instr", 64'(out_instr), 64'h22222222);
    chk("d1_pc", 64'(out_pc_plus1), 64'd11);
    chk("d1_ready", 64'(in_ready), 64'd1);
    cyc(0, 32'h0, 32'h0, 1, 0);
    idle_chk("d_end");

    // FULL then flush with a simultaneous incoming word
    cyc(1, 32'h44444444, 32'd20, 0, 0);
    cyc(1, 32'h55555555, 32'd21, 0, 0);
    chk("fl_full", 64'(in_ready), 64'd0);
    cyc(1, 32'h08000010, 32'd22, 0, 1);
    idle_chk("fl");
`ifdef IFID_PERF_CNT_EN
    chk("fl_perf_flushed", 64'(perf_flushed), 64'd2);
    chk("fl_perf_accepted", 64'(perf_accepted), 64'd7);
`endif
    cyc(0, 32'h0, 32'h0, 1, 0);
    idle_chk("fl_after");
    chk("fl_hold_instr", 64'(out_instr), 64'h44444444);

    // Flush coinciding with decode consuming the main entry
    cyc(1, 32'h66666666, 32'd30, 0, 0);
    cyc(0, 32'h0, 32'h0, 1, 1);
    idle_chk("flc");

    // Random traffic against the model
    for (int k = 0; k < 1000; k++) begin
      cyc(1'($urandom_range(0, 3) != 0), 32'hA000_0000 + 32'(k), 32'(k),
          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));
    end

    // Asynchronous reset while FULL
    cyc(1, 32'h77777777, 32'd40, 0, 0);
    cyc(1, 32'h88888888, 32'd41, 0, 0);
    cyc(0, 32'h0, 32'h0, 0, 0);
    chk("ar_full", 64'(in_ready), 64'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_valid", 64'(out_valid), 64'd0);
    chk("ar_ready", 64'(in_ready), 64'd1);
    chk("ar_instr", 64'(out_instr), 64'h0);
    chk("ar_pc", 64'(out_pc_plus1), 64'h0);
`ifdef IFID_PERF_CNT_EN
    chk("ar_perf", 64'(perf_accepted), 64'h0);
`endif
    @(posedge clk); #1;
    reset = 1'b0;
    cyc(0, 32'h0, 32'h0, 1, 0);
    idle_chk("ar_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
